// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops FIFO words into a prefetch/output pair and streams them LSB-first as OUT_WIDTH slices
module fifo_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_re_o,
    input  logic                 enable_i,
    input  logic                 flush_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic [15:0]          words_read_o
);
    localparam int SLICES = WIDTH / OUT_WIDTH;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    logic [WIDTH-1:0] pb, ow;
    logic             pv, ov, acc, load;
    logic [IW-1:0]    idx;
    logic [15:0]      cnt;
    // Pop is gated by reset so the FIFO is never drained while state is held cleared
    always_comb begin
        out_last_o  = ov & (idx == IW'(SLICES - 1));
        out_valid_o = ov;
        busy_o      = pv | ov;
        acc         = ov & out_ready_i;
        load        = pv & (~ov | (acc & out_last_o));
        fifo_re_o   = rst_ni & enable_i & ~fifo_empty_i & ~flush_i & (~pv | load);
    end
    assign out_data_o   = ow[int'(idx) * OUT_WIDTH +: OUT_WIDTH];
    assign words_read_o = cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pb  <= '0;
            ow  <= '0;
            pv  <= 1'b0;
            ov  <= 1'b0;
            idx <= '0;
            cnt <= '0;
        end else begin
            if (fifo_re_o) begin
                pb  <= fifo_rdata_i;
                cnt <= cnt + 16'd1;
            end
            if (flush_i) begin
                pv  <= 1'b0;
                ov  <= 1'b0;
                idx <= '0;
            end else begin
                pv <= fifo_re_o | (pv & ~load);
                if (load) begin
                    ow  <= pb;
                    ov  <= 1'b1;
                    idx <= '0;
                end else if (acc & out_last_o) begin
                    ov <= 1'b0;
                end else if (acc) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of the slice streamer plus a byte-wide instance for counter wrap
module tb_fifo_stream_reader;
    localparam logic [31:0] W0 = 32'h44332211;
    localparam logic [31:0] W1 = 32'h88776655;
    localparam logic [31:0] W2 = 32'hCCBBAA99;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rdata;
    logic        empty, re, en, flush, rdy;
    logic [7:0]  data;
    logic        valid, last, busy;
    logic [15:0] words;
    logic [31:0] mem [0:7];
    int          wptr, rptr;
    logic [7:0]  rdata2, d2;
    logic        empty2 = 1'b0, rdy2 = 1'b1, re2, en2, flush2 = 1'b0;
    logic        v2, last2, busy2;
    logic [15:0] w2;
    logic [31:0] wp2;
    int          rcv2 = 0, sb_err = 0;
    int          checks = 0, errors = 0;
    logic [63:0] dw;
    logic [95:0] tw;
    int          k;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fifo_rdata_i(rdata), .fifo_empty_i(empty),
        .fifo_re_o(re), .enable_i(en), .flush_i(flush), .out_data_o(data),
        .out_valid_o(valid), .out_ready_i(rdy), .out_last_o(last), .busy_o(busy),
        .words_read_o(words)
    );

    fifo_stream_reader #(.WIDTH(8), .OUT_WIDTH(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .fifo_rdata_i(rdata2), .fifo_empty_i(empty2),
        .fifo_re_o(re2), .enable_i(en2), .flush_i(flush2), .out_data_o(d2),
        .out_valid_o(v2), .out_ready_i(rdy2), .out_last_o(last2), .busy_o(busy2),
        .words_read_o(w2)
    );

    assign rdata  = mem[rptr % 8];
    assign empty  = (rptr == wptr);
    assign rdata2 = wp2[7:0] ^ 8'hA5;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) rptr <= 0;
        else if (re) rptr <= rptr + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) wp2 <= '0;
        else if (re2) wp2 <= wp2 + 32'd1;

    always @(negedge clk)
        if (v2 && rdy2) begin
            if (d2 !== (8'(rcv2) ^ 8'hA5)) sb_err++;
            rcv2++;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        rdy   = 1'b1;
        wptr  = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        en2   = 1'b0;
        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        rdy   = 1'b1;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        wptr  = 1;
        #3;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", re, 0);
        chk("rst_words", words, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        chk("dis_re", re, 0);
        chk("dis_words", words, 0);
        chk("dis_valid", valid, 0);

        en = 1'b1;
        #1;
        chk("t2_re_c0", re, 1);
        tick();
        #1;
        chk("t2_re_c1", re, 0);
        chk("t2_valid_c1", valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("t2_valid", valid, 1);
            chk("t2_data", data, W0[i*8 +: 8]);
            chk("t2_last", last, (i == 3) ? 1 : 0);
        end
        tick();
        #1;
        chk("t2_busy_c6", busy, 0);
        chk("t2_words", words, 1);

        do_reset();
        wptr = 2;
        en   = 1'b1;
        dw   = {W1, W0};
        #1;
        chk("t3_re_c0", re, 1);
        tick();
        #1;
        chk("t3_re_c1", re, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            chk("t3_valid", valid, 1);
            chk("t3_data", data, dw[i*8 +: 8]);
            chk("t3_last", last, (i == 3 || i == 7) ? 1 : 0);
        end
        tick();
        #1;
        chk("t3_busy", busy, 0);
        chk("t3_words", words, 2);

        do_reset();
        wptr = 3;
        en   = 1'b1;
        tw   = {W2, W1, W0};
        k    = 0;
        for (int c = 0; c < 25; c++) begin
            rdy = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("t4_hold_data", data, 8'h22);
                chk("t4_hold_valid", valid, 1);
                chk("t4_hold_re", re, 0);
            end
            if (valid && rdy && k < 12) begin
                chk("t4_slice", data, tw[k*8 +: 8]);
                k++;
            end
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("t4_count", k, 12);
        chk("t4_words", words, 3);
        chk("t4_busy", busy, 0);

        do_reset();
        wptr = 3;
        en   = 1'b1;
        #1;
        tick();
        tick();
        #1;
        chk("t5_c2_data", data, 8'h11);
        tick();
        flush = 1'b1;
        #1;
        chk("t5_c3_data", data, 8'h22);
        chk("t5_c3_valid", valid, 1);
        chk("t5_c3_re", re, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_valid", valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_words", words, 2);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid && rdy && k < 4) begin
                chk("t5_slice", data, W2[k*8 +: 8]);
                k++;
            end
            tick();
            #1;
        end
        chk("t5_count", k, 4);
        chk("t5_words_end", words, 3);

        en2 = 1'b1;
        for (int i = 0; i < 70000 && w2 !== 16'hFFFF; i++) @(negedge clk);
        chk("t6_ffff", w2, 16'hFFFF);
        @(negedge clk);
        chk("t6_0000", w2, 16'h0000);
        @(negedge clk);
        chk("t6_0001", w2, 16'h0001);
        en2 = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_received", rcv2, 65537);
        chk("t6_sb_err", sb_err, 0);
        chk("t6_busy", busy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
